// File: rtl/axis_pkt_fifo_pkg.sv
// Shared state encoding and sizing helper for the AXI-Stream packet FIFO.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package axis_pkt_fifo_pkg;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_t;

    // Pointers carry one extra MSB as a wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// DEPTH x WIDTH storage array, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller gates wr_en.
module axis_pkt_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: contents are only ever read behind a valid pointer range.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO, cut-through or store-and-forward; AXIS_PKT_FIFO_ERR_DROP_EN drops tuser-flagged packets.
// Latency: m_tvalid one cycle after an accepted beat (cut-through) or after the accepted tlast (packet mode).
// Backpressure: s_tready low while full, forced high while discarding an oversize packet.
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    o_empty,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_word_count,
    output logic [$clog2(DEPTH):0]  o_pkt_count,
    output logic                    o_drop
);

    localparam int              PW      = ptr_width(DEPTH);
    localparam int              AW      = PW - 1;
    localparam logic [PW-1:0]   DEPTH_W = PW'(DEPTH);
    localparam logic [PW-1:0]   ONE     = PW'(1);
    localparam bit              PKT     = (PACKET_MODE != 0);

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr, wr_commit, rd_ptr, pkt_count, commit_ptr, used;
    logic            rdy_en, full, push, pop, store, commit, size_drop, err_drop, err_flag;
    logic [DATA_WIDTH:0] rd_dat;

`ifdef AXIS_PKT_FIFO_ERR_DROP_EN
    assign err_flag = PKT && s_tuser;
`else
    logic unused_tuser;
    assign unused_tuser = s_tuser;
    assign err_flag     = 1'b0;
`endif

    assign used       = wr_ptr - rd_ptr;
    assign full       = (used == DEPTH_W);
    assign commit_ptr = PKT ? wr_commit : wr_ptr;
    // rdy_en holds s_tready low through reset and rises on the first edge after release.
    assign s_tready   = rdy_en && ((state_q == ST_DROP) || !full);
    assign push       = s_tvalid && s_tready;
    assign m_tvalid   = (rd_ptr != commit_ptr);
    assign pop        = m_tvalid && m_tready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        store     = 1'b0;
        commit    = 1'b0;
        size_drop = 1'b0;
        err_drop  = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                store = push;
                // Whole FIFO holds one unfinished packet: it can never complete, so discard it.
                if (PKT && full && (wr_commit == rd_ptr)) begin
                    size_drop = 1'b1;
                    store     = 1'b0;
                    state_d   = ST_DROP;
                end else if (push && s_tlast) begin
                    if (err_flag) begin
                        err_drop = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (push && s_tlast) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
        if (i_clear) begin
            state_d = ST_ACCEPT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_en    <= 1'b0;
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (i_clear) begin
                wr_ptr    <= '0;
                wr_commit <= '0;
                rd_ptr    <= '0;
                pkt_count <= '0;
            end else begin
                if (size_drop || err_drop) begin
                    wr_ptr <= wr_commit;
                end else if (store) begin
                    wr_ptr <= wr_ptr + ONE;
                end
                if (commit) begin
                    wr_commit <= wr_ptr + ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ONE;
                end
                if (commit && !(pop && m_tlast)) begin
                    pkt_count <= pkt_count + ONE;
                end else if (!commit && pop && m_tlast) begin
                    pkt_count <= pkt_count - ONE;
                end
            end
        end
    end

    axis_pkt_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (store),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_tlast, s_tdata}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_dat)
    );

    assign m_tlast      = rd_dat[DATA_WIDTH];
    assign m_tdata      = rd_dat[DATA_WIDTH-1:0];
    assign o_empty      = (used == '0);
    assign o_full       = full;
    assign o_word_count = used;
    assign o_pkt_count  = pkt_count;
    assign o_drop       = size_drop || err_drop;

endmodule
